// File: rtl/oy_toplama.sv
// oy_toplama: ballot collection stage feeding the election-result block.
// Saturating 2-bit per-party counts for four boxes, published on poll close.
module oy_toplama #(
   parameter int TOPLAM_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                baslat,
   input  logic                kapat,
   input  logic                oy_gecerli,
   output logic                oy_hazir,
   input  logic [1:0]          oy_sandik,
   input  logic                oy_parti,
   output logic [7:0]          T,
   output logic [7:0]          H,
   output logic                sonuc_gecerli,
   output logic [3:0]          tasma,
   output logic [TOPLAM_W-1:0] toplam_oy
);

   typedef enum logic [1:0] {BOS, ACIK, SAYIM, SONUC} durum_e;

   localparam logic [TOPLAM_W-1:0] BIR  = TOPLAM_W'(1);
   localparam logic [TOPLAM_W-1:0] DOLU = '1;

   durum_e              durum_q, durum_d;
   logic [7:0]          t_say_q, t_say_d;
   logic [7:0]          h_say_q, h_say_d;
   logic [7:0]          t_q, t_d;
   logic [7:0]          h_q, h_d;
   logic [3:0]          ovf_q, ovf_d;
   logic [3:0]          tasma_q, tasma_d;
   logic                sonuc_q, sonuc_d;
   logic [TOPLAM_W-1:0] toplam_q, toplam_d;

   logic                kabul;
   logic                temizle;
   logic [2:0]          ofs;
   logic [1:0]          secili;

   assign oy_hazir      = (durum_q == ACIK);
   assign kabul         = oy_gecerli && oy_hazir;
   assign temizle       = baslat && ((durum_q == BOS) || (durum_q == SONUC));
   assign ofs           = {oy_sandik, 1'b0};
   assign secili        = oy_parti ? t_say_q[ofs +: 2] : h_say_q[ofs +: 2];

   assign T             = t_q;
   assign H             = h_q;
   assign tasma         = tasma_q;
   assign sonuc_gecerli = sonuc_q;
   assign toplam_oy     = toplam_q;

   always_comb begin
      durum_d = durum_q;
      unique case (durum_q)
         BOS:   if (baslat) durum_d = ACIK;
         ACIK:  if (kapat)  durum_d = SAYIM;
         SAYIM:             durum_d = SONUC;
         SONUC: if (baslat) durum_d = ACIK;
      endcase
   end

   always_comb begin
      t_say_d  = t_say_q;
      h_say_d  = h_say_q;
      t_d      = t_q;
      h_d      = h_q;
      ovf_d    = ovf_q;
      tasma_d  = tasma_q;
      sonuc_d  = sonuc_q;
      toplam_d = toplam_q;

      if (temizle) begin
         t_say_d  = '0;
         h_say_d  = '0;
         t_d      = '0;
         h_d      = '0;
         ovf_d    = '0;
         tasma_d  = '0;
         sonuc_d  = 1'b0;
         toplam_d = '0;
      end else if (kabul) begin
         if (secili == 2'd3) begin
            ovf_d[oy_sandik] = 1'b1;
         end else if (oy_parti) begin
            t_say_d[ofs +: 2] = secili + 2'd1;
         end else begin
            h_say_d[ofs +: 2] = secili + 2'd1;
         end
         if (toplam_q != DOLU) toplam_d = toplam_q + BIR;
      end

      // overflow flags stay internal until publish so tasma is stable in ACIK
      if (durum_q == SAYIM) begin
         t_d     = t_say_q;
         h_d     = h_say_q;
         tasma_d = ovf_q;
         sonuc_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         durum_q  <= BOS;
         t_say_q  <= '0;
         h_say_q  <= '0;
         t_q      <= '0;
         h_q      <= '0;
         ovf_q    <= '0;
         tasma_q  <= '0;
         sonuc_q  <= 1'b0;
         toplam_q <= '0;
      end else begin
         durum_q  <= durum_d;
         t_say_q  <= t_say_d;
         h_say_q  <= h_say_d;
         t_q      <= t_d;
         h_q      <= h_d;
         ovf_q    <= ovf_d;
         tasma_q  <= tasma_d;
         sonuc_q  <= sonuc_d;
         toplam_q <= toplam_d;
      end
   end

endmodule
